// File: rtl/round_seq_pkg.sv
// Shared types and constants for the light-pattern round sequencer.
package round_seq_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StGen   = 3'd1,
      StShow  = 3'd2,
      StGap   = 3'd3,
      StApply = 3'd4,
      StGood  = 3'd5,
      StBurn  = 3'd6,
      StEnd   = 3'd7
   } state_e;

   localparam logic [7:0] SEG_GOOD  = 8'd255;
   localparam logic [7:0] SEG_END   = 8'd253;
   localparam logic [3:0] NO_PRESS  = 4'b1111;
   localparam logic [3:0] LFSR_SEED = 4'b1001;

   function automatic logic [3:0] lfsr_next(input logic [3:0] r);
      return {r[3] ^ r[2] ^ r[0], r[3:1]};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Game-tick prescaler: counts 0..CLK_DIV-1 and pulses o_tick for one cycle on wrap.
module tick_prescaler #(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CntW-1:0] r_cnt;

   assign o_tick = (r_cnt == CntW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// Round controller for the light-pattern game.
// Define ROUND_SEQ_RETRY_EN to replay the same pattern after a BURN instead of regenerating.
module round_sequencer
   import round_seq_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 50_000_000,
   parameter int unsigned PAT_LEN       = 7,
   parameter int unsigned MAX_LEVEL     = 10,
   parameter int unsigned TIMEOUT_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [3:0] change_i,
   output logic [3:0] light_o,
   output logic [7:0] seg7_o,
   output logic [7:0] level_o,
   output logic [1:0] difficulty_o,
   output logic [2:0] phase_o,
   output logic       end_o
);

   localparam int unsigned IdxW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

   state_e            r_state, w_state_d;
   logic [IdxW-1:0]   r_idx, w_idx_d;
   logic [7:0]        r_tcnt, w_tcnt_d;
   logic [3:0]        r_lfsr, w_lfsr_d, w_lfsr_nx;
   logic [3:0]        r_pat [PAT_LEN];
   logic [3:0]        r_prev;
   logic [7:0]        r_level, w_level_d;
   logic [1:0]        r_diff, w_diff_d;
   logic [3:0]        r_light, w_light_d;
   logic [7:0]        r_seg7, w_seg7_d;
   logic              r_end, w_end_d;
   logic              w_tick, w_clr, w_pat_we, w_accept, w_idx_last;
   logic [3:0]        w_entry;

   // Every state change restarts the tick period so each state gets full ticks.
   assign w_clr = (w_state_d != r_state);

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

   assign w_lfsr_nx  = lfsr_next(r_lfsr);
   assign w_entry    = 4'b0001 << w_lfsr_nx[1:0];
   assign w_idx_last = (r_idx == IdxW'(PAT_LEN - 1));
   assign w_accept   = (r_prev == NO_PRESS) && (change_i != NO_PRESS);

   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      w_tcnt_d  = r_tcnt;
      w_lfsr_d  = r_lfsr;
      w_level_d = r_level;
      w_diff_d  = r_diff;
      w_pat_we  = 1'b0;
      case (r_state)
         StIdle: begin
            if (start_i) begin
               w_state_d = StGen;
               w_idx_d   = '0;
            end else begin
               w_lfsr_d = w_lfsr_nx;
            end
         end
         StGen: begin
            w_lfsr_d = w_lfsr_nx;
            w_pat_we = 1'b1;
            if (w_idx_last) begin
               w_state_d = StShow;
               w_idx_d   = '0;
               w_tcnt_d  = '0;
            end else begin
               w_idx_d = r_idx + 1'b1;
            end
         end
         StShow: begin
            if (w_tick) begin
               if (r_tcnt == {6'd0, 2'd3 - r_diff}) begin
                  w_state_d = StGap;
                  w_tcnt_d  = '0;
               end else begin
                  w_tcnt_d = r_tcnt + 1'b1;
               end
            end
         end
         StGap: begin
            if (w_tick) begin
               w_tcnt_d = '0;
               if (w_idx_last) begin
                  w_state_d = StApply;
                  w_idx_d   = '0;
               end else begin
                  w_state_d = StShow;
                  w_idx_d   = r_idx + 1'b1;
               end
            end
         end
         StApply: begin
            // An accepted press takes priority, so mismatch plus timeout is one BURN.
            if (w_accept) begin
               w_tcnt_d = '0;
               if (change_i != r_pat[r_idx]) begin
                  w_state_d = StBurn;
               end else if (w_idx_last) begin
                  w_state_d = StGood;
                  w_idx_d   = '0;
               end else begin
                  w_idx_d = r_idx + 1'b1;
               end
            end else if (w_tick) begin
               if (r_tcnt == 8'(TIMEOUT_TICKS - 1)) begin
                  w_state_d = StBurn;
                  w_tcnt_d  = '0;
               end else begin
                  w_tcnt_d = r_tcnt + 1'b1;
               end
            end
         end
         StGood: begin
            if (w_tick) begin
               if (r_tcnt == 8'd1) begin
                  w_tcnt_d = '0;
                  w_idx_d  = '0;
                  w_diff_d = (r_diff == 2'd3) ? 2'd3 : r_diff + 1'b1;
                  if (r_level == 8'(MAX_LEVEL)) begin
                     w_state_d = StEnd;
                  end else begin
                     w_level_d = r_level + 1'b1;
                     w_state_d = StGen;
                  end
               end else begin
                  w_tcnt_d = r_tcnt + 1'b1;
               end
            end
         end
         StBurn: begin
            if (w_tick) begin
               if (r_tcnt == 8'd1) begin
                  w_tcnt_d = '0;
                  w_idx_d  = '0;
                  w_diff_d = (r_diff == 2'd0) ? 2'd0 : r_diff - 1'b1;
`ifdef ROUND_SEQ_RETRY_EN
                  w_state_d = StShow;
`else
                  w_state_d = StGen;
`endif
               end else begin
                  w_tcnt_d = r_tcnt + 1'b1;
               end
            end
         end
         StEnd: begin
            if (start_i) begin
               w_level_d = 8'd1;
               w_diff_d  = 2'd0;
               w_idx_d   = '0;
               w_state_d = StGen;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs are computed from next-state values so the registered copies track r_state.
   always_comb begin
      w_light_d = 4'b0000;
      if (w_state_d == StShow) begin
         w_light_d = (w_pat_we && (r_idx == w_idx_d)) ? w_entry : r_pat[w_idx_d];
      end
      case (w_state_d)
         StGood:        w_seg7_d = SEG_GOOD;
         StBurn, StEnd: w_seg7_d = SEG_END;
         default:       w_seg7_d = w_level_d;
      endcase
      w_end_d = (w_state_d == StEnd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_idx   <= '0;
         r_tcnt  <= '0;
         r_lfsr  <= LFSR_SEED;
         r_pat   <= '{default: '0};
         r_prev  <= NO_PRESS;
         r_level <= 8'd1;
         r_diff  <= 2'd0;
         r_light <= 4'b0000;
         r_seg7  <= 8'd1;
         r_end   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
         r_tcnt  <= w_tcnt_d;
         r_lfsr  <= w_lfsr_d;
         r_prev  <= change_i;
         r_level <= w_level_d;
         r_diff  <= w_diff_d;
         r_light <= w_light_d;
         r_seg7  <= w_seg7_d;
         r_end   <= w_end_d;
         if (w_pat_we) begin
            r_pat[r_idx] <= w_entry;
         end
      end
   end

   assign light_o      = r_light;
   assign seg7_o       = r_seg7;
   assign level_o      = r_level;
   assign difficulty_o = r_diff;
   assign phase_o      = r_state;
   assign end_o        = r_end;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed scoreboard bench for round_sequencer (CLK_DIV = 4, MAX_LEVEL = 2).
module tb_round_sequencer;
   import round_seq_pkg::*;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned PAT_LEN = 7;
   localparam int unsigned MAX_LVL = 2;
   localparam int unsigned TMO     = 8;

   logic       clk;
   logic       rst_n;
   logic       start_i;
   logic [3:0] change_i;
   logic [3:0] light_o;
   logic [7:0] seg7_o;
   logic [7:0] level_o;
   logic [1:0] difficulty_o;
   logic [2:0] phase_o;
   logic       end_o;

   int         n_cmp  = 0;
   int         n_fail = 0;
   int         m_level;
   int         m_diff;
   logic [3:0] m_lfsr;
   logic [3:0] m_pat [PAT_LEN];
   logic [3:0] q_exp [$];
   logic [3:0] wrong;

   round_sequencer #(
      .CLK_DIV       (CLK_DIV),
      .PAT_LEN       (PAT_LEN),
      .MAX_LEVEL     (MAX_LVL),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .change_i     (change_i),
      .light_o      (light_o),
      .seg7_o       (seg7_o),
      .level_o      (level_o),
      .difficulty_o (difficulty_o),
      .phase_o      (phase_o),
      .end_o        (end_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_phase(input state_e p, input string tag);
      int n = 0;
      while (phase_o !== p && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(phase_o), 32'(p));
   endtask

   task automatic dwell(input state_e p, input int exp_n, input string tag);
      int n = 0;
      while (phase_o === p && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check(tag, n, exp_n);
   endtask

   // Model the LFSR for one GEN phase and queue the expected lamp sequence.
   task automatic gen_round();
      for (int i = 0; i < PAT_LEN; i++) begin
         m_lfsr   = {m_lfsr[3] ^ m_lfsr[2] ^ m_lfsr[0], m_lfsr[3:1]};
         m_pat[i] = 4'b0001 << m_lfsr[1:0];
         q_exp.push_back(m_pat[i]);
      end
      dwell(StGen, PAT_LEN, "gen_len");
   endtask

   task automatic run_show();
      logic [3:0] e;
      for (int s = 0; s < PAT_LEN; s++) begin
         wait_phase(StShow, "show_enter");
         e = 4'hx;
         if (q_exp.size() > 0) e = q_exp.pop_front();
         check("show_light", 32'(light_o), 32'(e));
         if (s == 0) check("show_seg7_level", 32'(seg7_o), m_level);
         dwell(StShow, (4 - m_diff) * CLK_DIV, "show_len");
         check("gap_light", 32'(light_o), 0);
         dwell(StGap, CLK_DIV, "gap_len");
      end
      check("apply_enter", 32'(phase_o), 32'(StApply));
   endtask

   task automatic press(input logic [3:0] v);
      change_i = v;
      @(negedge clk);
      change_i = NO_PRESS;
   endtask

   task automatic press_from(input int first);
      for (int i = first; i < PAT_LEN; i++) begin
         press(m_pat[i]);
         if (i < PAT_LEN - 1) @(negedge clk);
      end
   endtask

   task automatic good_round();
      check("good_phase", 32'(phase_o), 32'(StGood));
      check("good_seg7", 32'(seg7_o), 32'(SEG_GOOD));
      dwell(StGood, 2 * CLK_DIV, "good_len");
      m_diff = (m_diff == 3) ? 3 : m_diff + 1;
      if (m_level != MAX_LVL) m_level++;
      check("good_level", 32'(level_o), m_level);
      check("good_diff", 32'(difficulty_o), m_diff);
   endtask

   task automatic burn_round(input string tag);
      check({tag, "_phase"}, 32'(phase_o), 32'(StBurn));
      check({tag, "_seg7"}, 32'(seg7_o), 32'(SEG_END));
      dwell(StBurn, 2 * CLK_DIV, {tag, "_len"});
      m_diff = (m_diff == 0) ? 0 : m_diff - 1;
      check({tag, "_level"}, 32'(level_o), m_level);
      check({tag, "_diff"}, 32'(difficulty_o), m_diff);
`ifdef ROUND_SEQ_RETRY_EN
      check({tag, "_retry_show"}, 32'(phase_o), 32'(StShow));
      for (int i = 0; i < PAT_LEN; i++) q_exp.push_back(m_pat[i]);
`else
      check({tag, "_to_gen"}, 32'(phase_o), 32'(StGen));
      gen_round();
`endif
   endtask

   initial begin
      rst_n    = 1'b0;
      start_i  = 1'b0;
      change_i = NO_PRESS;
      m_level  = 1;
      m_diff   = 0;
      m_lfsr   = LFSR_SEED;
      repeat (3) @(negedge clk);
      check("rst_light", 32'(light_o), 0);
      check("rst_seg7", 32'(seg7_o), 1);
      check("rst_level", 32'(level_o), 1);
      check("rst_diff", 32'(difficulty_o), 0);
      check("rst_phase", 32'(phase_o), 32'(StIdle));
      check("rst_end", 32'(end_o), 0);

      rst_n   = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("start_gen", 32'(phase_o), 32'(StGen));
      gen_round();

      // Round 1: wrong first press.
      run_show();
      wrong = (m_pat[0] == 4'b1000) ? 4'b0001 : 4'b1000;
      press(wrong);
      burn_round("wrong");

      // Round 2: no press at all; a stray start_i is ignored.
      run_show();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("start_ignored", 32'(phase_o), 32'(StApply));
      dwell(StApply, TMO * CLK_DIV - 1, "timeout_len");
      burn_round("timeout");

      // Round 3: first press held for 5 ticks must count once.
      run_show();
      change_i = m_pat[0];
      repeat (5 * CLK_DIV) @(negedge clk);
      change_i = NO_PRESS;
      @(negedge clk);
      press_from(1);
      good_round();
      check("r3_to_gen", 32'(phase_o), 32'(StGen));
      gen_round();

      // Round 4: clearing MAX_LEVEL ends the game.
      run_show();
      press_from(0);
      good_round();
      check("end_phase", 32'(phase_o), 32'(StEnd));
      check("end_flag", 32'(end_o), 1);
      check("end_seg7", 32'(seg7_o), 32'(SEG_END));
      repeat (10) @(negedge clk);
      check("end_sticky", 32'(end_o), 1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      m_level = 1;
      m_diff  = 0;
      check("restart_phase", 32'(phase_o), 32'(StGen));
      check("restart_level", 32'(level_o), 1);
      check("restart_diff", 32'(difficulty_o), 0);
      check("restart_seg7", 32'(seg7_o), 1);
      gen_round();

      // Asynchronous reset mid-SHOW.
      wait_phase(StShow, "pre_reset_show");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_light", 32'(light_o), 0);
      check("arst_seg7", 32'(seg7_o), 1);
      check("arst_level", 32'(level_o), 1);
      check("arst_diff", 32'(difficulty_o), 0);
      check("arst_phase", 32'(phase_o), 32'(StIdle));
      check("arst_end", 32'(end_o), 0);
      @(negedge clk);
      rst_n   = 1'b1;
      start_i = 1'b1;
      q_exp.delete();
      m_lfsr  = LFSR_SEED;
      @(negedge clk);
      start_i = 1'b0;
      check("post_rst_gen", 32'(phase_o), 32'(StGen));
      gen_round();
      run_show();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
